// File: rtl/fanout_sequencer_if.sv
// Handshake/bus bundle for fanout_sequencer.
//   start/seed         : transaction request from the control FSM
//   busy/done          : transaction status back to the control FSM
//   ch_req/ch_data     : per-channel request and stimulus (channel i at [i*DATA_W +: DATA_W])
//   ch_ack/ch_result   : per-channel acknowledge and result (channel i at [i*RESULT_W +: RESULT_W])
//   result_sum         : sum of captured results
//   timeout_err/err_ch : last transaction timed out / lowest unacked channel
// master = sequencer side, slave = environment (control FSM + child bank).
interface fanout_sequencer_if #(
  parameter int DATA_W   = 8,
  parameter int RESULT_W = 16,
  parameter int NUM_CH   = 4
);
  localparam int SUM_W = RESULT_W + $clog2(NUM_CH);

  logic                         start;
  logic [DATA_W-1:0]            seed;
  logic                         busy;
  logic                         done;
  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH*DATA_W-1:0]     ch_data;
  logic [NUM_CH-1:0]            ch_ack;
  logic [NUM_CH*RESULT_W-1:0]   ch_result;
  logic [SUM_W-1:0]             result_sum;
  logic                         timeout_err;
  logic [3:0]                   err_ch;

  modport master (
    input  start, seed, ch_ack, ch_result,
    output busy, done, ch_req, ch_data, result_sum, timeout_err, err_ch
  );

  modport slave (
    output start, seed, ch_ack, ch_result,
    input  busy, done, ch_req, ch_data, result_sum, timeout_err, err_ch
  );
endinterface

// File: rtl/fanout_sequencer.sv
// fanout_sequencer: drives NUM_CH identical child units over req/ack, captures
// each child's result and reports their sum, with a per-transaction timeout.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fanout_sequencer_if.master (start/seed/busy/done, ch_req/ch_data,
//           ch_ack/ch_result, result_sum/timeout_err/err_ch)
// Optional build macro FANOUT_SERIAL_ISSUE_EN: issue channels one at a time in
// index order, timeout restarting for each channel. Undefined: parallel issue.

// One channel: request flag, stimulus word, captured result and got flag.
module fanout_lane #(
  parameter int DATA_W   = 8,
  parameter int RESULT_W = 16,
  parameter int IDX      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,    // accepted start
  input  logic                issue,   // request this channel on load
  input  logic                adv,     // request this channel now
  input  logic                abort,   // timeout: drop request
  input  logic [DATA_W-1:0]   seed,
  input  logic                ack,
  input  logic [RESULT_W-1:0] result,
  output logic                req,
  output logic                hit,
  output logic                got,
  output logic [DATA_W-1:0]   data,
  output logic [RESULT_W-1:0] res
);
  // ack without an outstanding request is ignored
  assign hit = req & ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req  <= 1'b0;
      got  <= 1'b0;
      data <= '0;
      res  <= '0;
    end else if (load) begin
      data <= seed + DATA_W'(IDX);   // wraps modulo 2^DATA_W
      req  <= issue;
      got  <= 1'b0;
    end else begin
      if (hit) begin
        res <= result;
        got <= 1'b1;
      end
      if (hit || abort) req <= 1'b0;
      else if (adv)     req <= 1'b1;
    end
  end
endmodule

module fanout_sequencer #(
  parameter int DATA_W   = 8,
  parameter int RESULT_W = 16,
  parameter int NUM_CH   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  fanout_sequencer_if.master bus
);
  localparam int SUM_W = RESULT_W + $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, ACCUM, DONE} state_t;
  state_t state, state_nxt;

  logic                             load, tmo, all_got, last_cnt, cnt_clr;
  logic [NUM_CH-1:0]                req, got, hit, issue, adv;
  logic [NUM_CH-1:0][DATA_W-1:0]    data;
  logic [NUM_CH-1:0][RESULT_W-1:0]  res, res_in;
  logic [CNT_W-1:0]                 cnt;
  logic [SUM_W-1:0]                 sum_c, sum_q;
  logic                             terr_q;
  logic [3:0]                       err_c, err_q;

  assign res_in   = bus.ch_result;
  assign load     = (state == IDLE) && bus.start;
  assign last_cnt = (cnt == CNT_W'(TIMEOUT - 1));
  // completion includes this edge's captures, so a last-cycle ack beats the timeout
  assign all_got  = &(got | hit);
  assign tmo      = (state == WAIT) && last_cnt && !all_got;

`ifdef FANOUT_SERIAL_ISSUE_EN
  // Channel i is requested on the edge that captures channel i-1; the
  // timeout window restarts with every capture.
  assign issue   = NUM_CH'(1);
  assign cnt_clr = |hit;
  always_comb begin
    adv = '0;
    for (int i = 1; i < NUM_CH; i++) adv[i] = hit[i-1];
  end
`else
  assign issue   = '1;
  assign adv     = '0;
  assign cnt_clr = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    fanout_lane #(.DATA_W(DATA_W), .RESULT_W(RESULT_W), .IDX(gi)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .issue  (issue[gi]),
      .adv    (adv[gi]),
      .abort  (tmo),
      .seed   (bus.seed),
      .ack    (bus.ch_ack[gi]),
      .result (res_in[gi]),
      .req    (req[gi]),
      .hit    (hit[gi]),
      .got    (got[gi]),
      .data   (data[gi]),
      .res    (res[gi])
    );
  end

  // Lowest channel still missing; in serial mode this is the active index.
  always_comb begin
    err_c = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (!(got[i] | hit[i])) err_c = 4'(i);
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_CH; i++) sum_c = sum_c + SUM_W'(res[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = WAIT;
      WAIT:    if (all_got)  state_nxt = ACCUM;
               else if (tmo) state_nxt = DONE;
      ACCUM:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // WAIT leaves before cnt can pass TIMEOUT-1, so no wrap handling needed
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (load)            cnt <= '0;
    else if (state == WAIT)   cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      terr_q <= 1'b0;
      err_q  <= '0;
    end else begin
      if (load)            terr_q <= 1'b0;
      if (state == ACCUM)  sum_q  <= sum_c;
      if (tmo) begin
        terr_q <= 1'b1;
        err_q  <= err_c;
        sum_q  <= '0;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.ch_req      = req;
  assign bus.ch_data     = data;
  assign bus.result_sum  = sum_q;
  assign bus.timeout_err = terr_q;
  assign bus.err_ch      = err_q;
endmodule

// File: tb/tb_fanout_sequencer.sv
// Directed bench for fanout_sequencer (4 channels, 8-bit data, 16-bit results,
// TIMEOUT 255). Children are modelled as ch_ack = ch_req & ack_en with fixed
// results 0x100*(i+1). Build with FANOUT_SERIAL_ISSUE_EN to match a serial DUT.
module tb_fanout_sequencer;
  localparam int DATA_W = 8, RESULT_W = 16, NUM_CH = 4, TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0] ack_en;
  int total = 0, bad = 0, done_cnt = 0;

  always #5 clk = ~clk;

  fanout_sequencer_if #(.DATA_W(DATA_W), .RESULT_W(RESULT_W), .NUM_CH(NUM_CH)) bus ();

  fanout_sequencer #(.DATA_W(DATA_W), .RESULT_W(RESULT_W), .NUM_CH(NUM_CH),
                     .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.ch_ack    = bus.ch_req & ack_en;
  assign bus.ch_result = {16'h0400, 16'h0300, 16'h0200, 16'h0100};

  always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Tick until done is seen or max cycles pass; n = cycles taken.
  task automatic wait_done(input int max, output int n);
`ifdef FANOUT_SERIAL_ISSUE_EN
    logic [NUM_CH-1:0] cur;
    cur = bus.ch_req;
`endif
    n = 0;
    while (bus.done !== 1'b1 && n < max) begin
      tick();
      n++;
`ifdef FANOUT_SERIAL_ISSUE_EN
      chk("onehot", 32'($onehot0(bus.ch_req)), 32'd1);
      if (bus.ch_req != '0 && bus.ch_req != cur) begin
        chk("order", 32'(bus.ch_req), 32'(cur << 1));
        cur = bus.ch_req;
      end
`endif
    end
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic go(input logic [7:0] s);
    bus.seed  = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d;
    reset = 1'b1; bus.start = 1'b0; bus.seed = '0; ack_en = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_req",  32'(bus.ch_req), 0);
    chk("rst_data", bus.ch_data, 0);
    chk("rst_sum",  32'(bus.result_sum), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    chk("rst_errch", 32'(bus.err_ch), 0);

    // Reset asserted while waiting on children
    go(8'h10);
    chk("w_busy", 32'(bus.busy), 1);
`ifdef FANOUT_SERIAL_ISSUE_EN
    chk("w_req", 32'(bus.ch_req), 32'h1);
`else
    chk("w_req", 32'(bus.ch_req), 32'hF);
`endif
    tick(); tick();
    d = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("ar_req",  32'(bus.ch_req), 0);
    chk("ar_busy", 32'(bus.busy), 0);
    chk("ar_data", bus.ch_data, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_done", 32'(bus.done), 0);
    chk("ar_nopulse", 32'(done_cnt), 32'(d));

    // All children ack immediately
    ack_en = '1;
    d = done_cnt;
    go(8'h10);
    chk("s2_data", bus.ch_data, 32'h13121110);
`ifdef FANOUT_SERIAL_ISSUE_EN
    chk("s2_req", 32'(bus.ch_req), 32'h1);
    wait_done(20, n);
    chk("s2_lat", 32'(n), 5);
`else
    chk("s2_req", 32'(bus.ch_req), 32'hF);
    tick();
    chk("s2_accum_req",  32'(bus.ch_req), 0);
    chk("s2_accum_done", 32'(bus.done), 0);
    chk("s2_accum_busy", 32'(bus.busy), 1);
    tick();
    chk("s2_done", 32'(bus.done), 1);
`endif
    chk("s2_sum",  32'(bus.result_sum), 32'h00A00);
    chk("s2_terr", 32'(bus.timeout_err), 0);
    tick();
    chk("s2_idle_busy", 32'(bus.busy), 0);
    chk("s2_idle_done", 32'(bus.done), 0);
    chk("s2_onepulse", 32'(done_cnt), 32'(d + 1));

`ifndef FANOUT_SERIAL_ISSUE_EN
    // Staggered acks: ch0 +1, ch3 +2, ch1 +5, ch2 +7
    ack_en = '0;
    go(8'hFE);
    chk("s3_data", bus.ch_data, 32'h0100FFFE);
    chk("s3_req0", 32'(bus.ch_req), 32'hF);
    ack_en = 4'b0001; tick();
    chk("s3_req1", 32'(bus.ch_req), 32'hE);
    ack_en = 4'b1001; tick();
    chk("s3_req2", 32'(bus.ch_req), 32'h6);
    tick(); tick();
    chk("s3_req4",  32'(bus.ch_req), 32'h6);
    chk("s3_hold",  bus.ch_data, 32'h0100FFFE);
    ack_en = 4'b1011; tick();
    chk("s3_req5", 32'(bus.ch_req), 32'h4);
    tick();
    ack_en = 4'b1111; tick();
    chk("s3_req7",  32'(bus.ch_req), 0);
    chk("s3_done7", 32'(bus.done), 0);
    tick();
    chk("s3_done8", 32'(bus.done), 1);
    chk("s3_sum",   32'(bus.result_sum), 32'h00A00);
    tick();
    chk("s3_idle", 32'(bus.busy), 0);
`endif

    // Channel 2 never acknowledges
    ack_en = 4'b1011;
    go(8'h20);
`ifdef FANOUT_SERIAL_ISSUE_EN
    wait_done(600, n);
    chk("s4_lat", 32'(n), 257);
`else
    repeat (254) tick();
    chk("s4_pre_req",  32'(bus.ch_req), 32'h4);
    chk("s4_pre_terr", 32'(bus.timeout_err), 0);
    chk("s4_pre_done", 32'(bus.done), 0);
    tick();
    chk("s4_done", 32'(bus.done), 1);
`endif
    chk("s4_req",   32'(bus.ch_req), 0);
    chk("s4_terr",  32'(bus.timeout_err), 1);
    chk("s4_errch", 32'(bus.err_ch), 2);
    chk("s4_sum",   32'(bus.result_sum), 0);
    tick();
    chk("s4_idle", 32'(bus.busy), 0);

    // start while busy is ignored; a later start runs normally
    ack_en = '0;
    d = done_cnt;
    go(8'h40);
    chk("s5_terr_clr", 32'(bus.timeout_err), 0);
    chk("s5_data", bus.ch_data, 32'h43424140);
    tick();
    bus.seed = 8'h77; bus.start = 1'b1;
    tick(); tick();
    bus.start = 1'b0;
    chk("s5_ignore", bus.ch_data, 32'h43424140);
    chk("s5_busy", 32'(bus.busy), 1);
    ack_en = '1;
    wait_done(20, n);
`ifdef FANOUT_SERIAL_ISSUE_EN
    chk("s5_lat", 32'(n), 5);
`else
    chk("s5_lat", 32'(n), 2);
`endif
    tick();
    chk("s5_idle1", 32'(bus.busy), 0);
    tick();
    chk("s5_noqueue", 32'(bus.busy), 0);
    go(8'h30);
    chk("s5b_data", bus.ch_data, 32'h33323130);
    wait_done(20, n);
    chk("s5b_sum",   32'(bus.result_sum), 32'h00A00);
    chk("s5b_terr",  32'(bus.timeout_err), 0);
    chk("s5b_errch", 32'(bus.err_ch), 2);
    tick();
    chk("s5_two_txn", 32'(done_cnt), 32'(d + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
